vector_lane_sequencer: RTL
==========================

Name: vector_lane_sequencer

Overview:
- Multi-lane vector integer execution sequencer for the vector processor core.
- Accepts one vector-vector operation with full source registers, vector length (vl) and mask.
- Processes LANE_NUM elements per cycle over ceil(vl/LANE_NUM) cycles and returns the assembled destination register through a valid/ready handshake.
- Sits between the vector register file read stage and the writeback stage.
- Successor to the single-issue datapath: lane count is parametrised, and it adds masking, tail handling and multi-cycle sequencing.

Parameters:
- LEN, 32, element width in bits (SEW fixed to LEN).
- VECTOR_SIZE, 8, elements per vector register.
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE).
- LANE_NUM, 2, elements processed per cycle. Must be a power of two and must be ≤ VECTOR_SIZE.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- in_op  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
- in_vl  input  ENTRY_INDEX_SIZE+1  active element count.
- in_vm  input  1  1 = unmasked, 0 = use in_mask.
- in_mask  input  VECTOR_SIZE  bit i enables element i when in_vm=0.
- in_vs1  input  VECTOR_SIZE*LEN  source 1, element i at bits [i*LEN +: LEN].
- in_vs2  input  VECTOR_SIZE*LEN  source 2.
- in_old_vd  input  VECTOR_SIZE*LEN  current destination contents.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_vd  output  VECTOR_SIZE*LEN  result register.
- busy  output  1  state != IDLE.

Behaviour:

States and transitions:
- States: IDLE, EXEC, DONE.
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_vd=0, element counter=0.
- Reset asserted in any state, including mid-EXEC or DONE with out_valid high, returns to reset values on the next edge. The pending operation is discarded and no result is produced.
- IDLE: when in_valid&&in_ready is sampled at edge T:
  - Capture op, vm, mask, vs1, vs2.
  - Load the result register with in_old_vd.
  - Set effective vl: vl_eff = min(in_vl, VECTOR_SIZE).
  - Clear the element counter.
  - Next state is EXEC, or DONE directly if vl_eff=0.
- EXEC: each cycle processes elements idx..idx+LANE_NUM-1, where idx is the counter, then idx += LANE_NUM.
  - When idx+LANE_NUM ≥ vl_eff, the next state is DONE.
  - EXEC lasts k = ceil(vl_eff/LANE_NUM) cycles (edges T+1..T+k).
  - out_valid goes high in the cycle after edge T+k.
  - If vl_eff=0, out_valid goes high in the cycle after edge T.
- DONE: out_valid=1, and out_vd is held stable until out_valid&&out_ready is sampled. The next state is then IDLE.
  - in_ready stays 0 throughout DONE; there is no accept in the same cycle as the output handshake.

Element update rule:
- Element i is written only if i < vl_eff and (vm=1 or mask[i]=1). Otherwise it keeps old_vd (tail-undisturbed, mask-undisturbed).
- Lanes whose index is ≥ vl_eff in the final partial group write nothing.

Arithmetic:
- Result = vs2 op vs1, LEN bits, wrap-around modulo 2^LEN, no flags.
- Shift amount = vs1[log2(LEN)-1:0].
- sra is arithmetic on signed vs2; srl and sll are logical.

Other rules:
- in_* inputs are ignored outside an IDLE accept.
- Upstream may change them freely after acceptance.
- busy = (state != IDLE).

Test Plan:
1. Add, LANE_NUM=2: vl=8, vm=1, vs1[i]=i, vs2[i]=100, accept at edge T → EXEC for 4 cycles, out_valid high after edge T+4, out_vd[i]=100+i for i=0..7.
2. Masked sub with tail: vl=5, vm=0, mask=8'b1010_1010, vs2[i]=50, vs1[i]=i, old_vd all 0xDEADBEEF → 3 EXEC cycles.
   - Elements 1 and 3 = 49 and 47.
   - Elements 0, 2, 4, 5, 6, 7 = 0xDEADBEEF.
3. Zero length: vl=0 → out_valid high the cycle after accept, out_vd == old_vd, no EXEC cycle.
4. Shifts and wrap-around: vs2=0x80000000, vs1=0x00000021 (amount 1).
   - sra → 0xC0000000.
   - srl → 0x40000000.
   - sll → 0x00000000.
   - add with vs2=0xFFFFFFFF, vs1=1 → 0x00000000.
5. Clamp and backpressure: vl=11 → treated as 8.
   - Hold out_ready=0 for 3 cycles: out_valid stays 1, out_vd stable, in_ready=0.
   - out_ready=1 → next cycle in_ready=1, busy=0.
6. Reset mid-operation: assert rst during the 2nd EXEC cycle → next cycle in_ready=1, out_valid=0, out_vd=0, busy=0.
   - Then a new vl=2 add completes normally with 1 EXEC cycle.

Source files
------------

// File: rtl/vector_lane_sequencer.sv
// Vector integer execution sequencer: accepts one vector-vector op, runs LANE_NUM
// elements per cycle over ceil(vl/LANE_NUM) cycles, then presents the assembled vd.

module vls_lane_alu #(
  parameter int LEN = 32
) (
  input  logic [2:0]     op_i,
  input  logic [LEN-1:0] a_i,
  input  logic [LEN-1:0] b_i,
  output logic [LEN-1:0] res_o
);
  localparam int SHW = $clog2(LEN);

  logic [SHW-1:0] sh;
  assign sh = b_i[SHW-1:0];

  always_comb begin
    case (op_i)
      3'd0:    res_o = a_i + b_i;
      3'd1:    res_o = a_i - b_i;
      3'd2:    res_o = a_i & b_i;
      3'd3:    res_o = a_i | b_i;
      3'd4:    res_o = a_i ^ b_i;
      3'd5:    res_o = a_i << sh;
      3'd6:    res_o = a_i >> sh;
      default: res_o = LEN'($signed(a_i) >>> sh);
    endcase
  end
endmodule

module vector_lane_sequencer #(
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LANE_NUM         = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [ENTRY_INDEX_SIZE:0]     in_vl,
  input  logic                          in_vm,
  input  logic [VECTOR_SIZE-1:0]        in_mask,
  input  logic [VECTOR_SIZE*LEN-1:0]    in_vs1,
  input  logic [VECTOR_SIZE*LEN-1:0]    in_vs2,
  input  logic [VECTOR_SIZE*LEN-1:0]    in_old_vd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VECTOR_SIZE*LEN-1:0]    out_vd,
  output logic                          busy
);
  localparam int EIS = ENTRY_INDEX_SIZE;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [EIS:0] STEP  = (EIS+1)'(LANE_NUM);
  localparam logic [EIS:0] VSMAX = (EIS+1)'(VECTOR_SIZE);

  logic [1:0]                        state_q, state_d;
  logic [2:0]                        op_q;
  logic                              vm_q;
  logic [VECTOR_SIZE-1:0]            mask_q;
  logic [VECTOR_SIZE-1:0][LEN-1:0]   vs1_q, vs2_q, vd_q, vd_d;
  logic [EIS:0]                      vl_q, idx_q, idx_d, vl_in_eff;
  logic                              accept;

  logic [LANE_NUM-1:0][EIS:0]        lane_pos;
  logic [LANE_NUM-1:0][EIS-1:0]      lane_sel;
  logic [LANE_NUM-1:0][LEN-1:0]      lane_res;
  logic [LANE_NUM-1:0]               lane_we;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_vd    = vd_q;
  assign accept    = in_valid && (state_q == S_IDLE);
  assign vl_in_eff = (in_vl > VSMAX) ? VSMAX : in_vl;

  // Lanes past vl_eff in the last partial group are gated off by lane_we.
  for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
    assign lane_pos[l] = idx_q + (EIS+1)'(l);
    assign lane_sel[l] = lane_pos[l][EIS-1:0];
    assign lane_we[l]  = (lane_pos[l] < vl_q) && (vm_q || mask_q[lane_sel[l]]);
    vls_lane_alu #(.LEN(LEN)) u_alu (
      .op_i  (op_q),
      .a_i   (vs2_q[lane_sel[l]]),
      .b_i   (vs1_q[lane_sel[l]]),
      .res_o (lane_res[l])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vd_d    = vd_q;
    case (state_q)
      S_IDLE: if (accept) begin
        vd_d    = in_old_vd;
        idx_d   = '0;
        state_d = (vl_in_eff == '0) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        for (int l = 0; l < LANE_NUM; l++)
          if (lane_we[l]) vd_d[lane_sel[l]] = lane_res[l];
        idx_d = idx_q + STEP;
        if (idx_q + STEP >= vl_q) state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vd_q    <= '0;
      op_q    <= '0;
      vm_q    <= 1'b0;
      mask_q  <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vl_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vd_q    <= vd_d;
      if (accept) begin
        op_q   <= in_op;
        vm_q   <= in_vm;
        mask_q <= in_mask;
        vs1_q  <= in_vs1;
        vs2_q  <= in_vs2;
        vl_q   <= vl_in_eff;
      end
    end
  end
endmodule
